// File: rtl/hls_deadlock_param_monitor_pkg.sv
// ---------------------------------------------------------------------------
// hls_deadlock_pkg
// Shared definitions for the parametrised HLS deadlock monitor:
//   - state_e      : debounce FSM states (CLEAR / SUSPECT / BLOCKED)
//   - src_w()      : width of the block_src index for a given source count
//   - DEF_*_MASK   : default source masks used by the top-level parameters
// No ports (package).
// ---------------------------------------------------------------------------
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  localparam logic [2:0] DEF_AXIS_CUR_MASK = 3'b010;
  localparam logic [2:0] DEF_AXIS_SUB_MASK = 3'b100;
  localparam logic [4:0] DEF_INST_MASK     = 5'b00000;

  // Index width for n sources; never narrower than one bit so the port exists
  // even for a single-source monitor.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hls_deadlock_param_monitor_if.sv
// ---------------------------------------------------------------------------
// hls_deadlock_param_monitor_if
// Bundles the monitor's observation inputs and its reporting outputs.
//   axis_block_sigs [NUM_AXIS] : per-stream blocked indications   (to monitor)
//   inst_idle_sigs  [NUM_IDLE] : sub-instance idle flags           (to monitor)
//   inst_block_sigs [NUM_INST] : sub-instance block outputs        (to monitor)
//   block                      : registered deadlock indication    (from monitor)
//   block_src       [SRC_W]    : index of the source that tripped  (from monitor)
//   stall_cnt       [CNT_W]    : consecutive suspect cycles        (from monitor)
// Modports: master = the process being watched, slave = the monitor.
// ---------------------------------------------------------------------------
interface hls_deadlock_param_monitor_if
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = 3,
  parameter int NUM_IDLE = 9,
  parameter int NUM_INST = 5,
  parameter int CNT_W    = 16
);

  localparam int SRC_W = src_w(NUM_AXIS + NUM_INST);

  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_IDLE-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic                block;
  logic [SRC_W-1:0]    block_src;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output axis_block_sigs,
    output inst_idle_sigs,
    output inst_block_sigs,
    input  block,
    input  block_src,
    input  stall_cnt
  );

  modport slave (
    input  axis_block_sigs,
    input  inst_idle_sigs,
    input  inst_block_sigs,
    output block,
    output block_src,
    output stall_cnt
  );

endinterface

// File: rtl/hls_deadlock_param_monitor_prio_enc.sv
// ---------------------------------------------------------------------------
// hls_deadlock_prio_enc
// Lowest-set-bit encoder: returns the index of the lowest set bit of i_vec,
// or 0 when no bit is set (callers only use it when some bit is set).
//   i_vec [N] : candidate source vector
//   o_idx [W] : index of lowest set bit
// ---------------------------------------------------------------------------
module hls_deadlock_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx
);

  // Scan downwards so the last hit, i.e. the lowest index, wins.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// ---------------------------------------------------------------------------
// hls_deadlock_param_monitor
// Per-dataflow-process deadlock monitor. Masks the AXI-stream and sub-instance
// block signals into one suspect term, debounces it over PERSIST consecutive
// cycles, then raises block, latches which source tripped and reports how long
// the stall has lasted.
//
// Ports:
//   clock : kernel clock
//   reset : synchronous active-high reset (dominates all inputs)
//   mon   : hls_deadlock_param_monitor_if.slave
//             in : axis_block_sigs, inst_idle_sigs, inst_block_sigs
//             out: block, block_src, stall_cnt
//
// Build option:
//   HLS_DEADLOCK_MON_STICKY_EN - when defined, BLOCKED is left only through
//   reset; block stays high, stall_cnt and block_src freeze once blocked.
// ---------------------------------------------------------------------------
module hls_deadlock_param_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int                  NUM_AXIS      = 3,
  parameter int                  NUM_IDLE      = 9,
  parameter int                  NUM_INST      = 5,
  parameter logic [NUM_AXIS-1:0] AXIS_CUR_MASK = DEF_AXIS_CUR_MASK,
  parameter logic [NUM_AXIS-1:0] AXIS_SUB_MASK = DEF_AXIS_SUB_MASK,
  parameter logic [NUM_INST-1:0] INST_MASK     = DEF_INST_MASK,
  parameter int                  PERSIST       = 1,
  parameter int                  CNT_W         = 16,
  parameter int                  IDLE_GATE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  hls_deadlock_param_monitor_if.slave  mon
);

  localparam int SRC_N = NUM_AXIS + NUM_INST;
  localparam int SRC_W = src_w(SRC_N);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   PERSIST_V = (CNT_W+1)'(PERSIST);

  // PERSIST must be reachable by the saturating counter.
  if (PERSIST < 1 || longint'(PERSIST) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_persist
    $error("hls_deadlock_param_monitor: PERSIST out of range 1..2^CNT_W-1");
  end

  // ---- suspect term (combinational from inputs) ----
  logic [SRC_N-1:0] w_src_vec;
  logic             w_idle_all;
  logic             w_suspect;
  logic [SRC_W-1:0] w_src_idx;

  // AXIS sources in the low bits, instance sources above them, so the encoder
  // index is directly the reported block_src numbering.
  assign w_src_vec  = {mon.inst_block_sigs & INST_MASK,
                       mon.axis_block_sigs & (AXIS_CUR_MASK | AXIS_SUB_MASK)};
  assign w_idle_all = &mon.inst_idle_sigs;
  assign w_suspect  = (|w_src_vec) && !((IDLE_GATE != 0) && w_idle_all);

  hls_deadlock_prio_enc #(
    .N (SRC_N),
    .W (SRC_W)
  ) u_prio_enc (
    .i_vec (w_src_vec),
    .o_idx (w_src_idx)
  );

  // ---- state / counter registers ----
  state_e           r_state;
  logic             r_block;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [SRC_W-1:0] r_block_src;

  state_e           w_state_nxt;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_reach;
  logic             w_src_load;

  // One extra bit so the PERSIST comparison cannot overflow at saturation.
  assign w_cnt_inc = {1'b0, r_stall_cnt} + 1'b1;
  assign w_cnt_sat = (r_stall_cnt == CNT_MAX) ? CNT_MAX : w_cnt_inc[CNT_W-1:0];
  assign w_reach   = (w_cnt_inc >= PERSIST_V);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_suspect ? w_cnt_sat : '0;
    w_src_load  = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        if (w_suspect) w_state_nxt = (PERSIST == 1) ? ST_BLOCKED : ST_SUSPECT;
      end
      ST_SUSPECT: begin
        if (!w_suspect)  w_state_nxt = ST_CLEAR;
        else if (w_reach) w_state_nxt = ST_BLOCKED;
      end
      ST_BLOCKED: begin
`ifdef HLS_DEADLOCK_MON_STICKY_EN
        // Latched deadlock: hold the report until reset.
        w_cnt_nxt = r_stall_cnt;
`else
        if (!w_suspect) w_state_nxt = ST_CLEAR;
`endif
      end
      default: w_state_nxt = ST_CLEAR;
    endcase

    if ((r_state != ST_BLOCKED) && (w_state_nxt == ST_BLOCKED)) w_src_load = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_block     <= 1'b0;
      r_stall_cnt <= '0;
      r_block_src <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_block     <= (w_state_nxt == ST_BLOCKED);
      r_stall_cnt <= w_cnt_nxt;
      if (w_src_load) r_block_src <= w_src_idx;
    end
  end

  assign mon.block     = r_block;
  assign mon.block_src = r_block_src;
  assign mon.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// ---------------------------------------------------------------------------
// tb_hls_deadlock_param_monitor
// Five monitor configurations watch the same input stream (each with its own
// reset): defaults, PERSIST=4, IDLE_GATE=1, INST_MASK=5'b10100, CNT_W=4 with
// PERSIST=3. A run-length reference model predicts block/block_src/stall_cnt.
// ---------------------------------------------------------------------------
module tb_hls_deadlock_param_monitor;

  localparam int NI = 5;

  logic          clk = 1'b0;
  logic [NI-1:0] rst = '1;

  always #5 clk = ~clk;

  hls_deadlock_param_monitor_if #(.CNT_W(16)) if0 ();
  hls_deadlock_param_monitor_if #(.CNT_W(16)) if1 ();
  hls_deadlock_param_monitor_if #(.CNT_W(16)) if2 ();
  hls_deadlock_param_monitor_if #(.CNT_W(16)) if3 ();
  hls_deadlock_param_monitor_if #(.CNT_W(4))  if4 ();

  hls_deadlock_param_monitor u0 (.clock(clk), .reset(rst[0]), .mon(if0.slave));

  hls_deadlock_param_monitor #(.PERSIST(4)) u1 (
    .clock(clk), .reset(rst[1]), .mon(if1.slave));

  hls_deadlock_param_monitor #(.IDLE_GATE(1)) u2 (
    .clock(clk), .reset(rst[2]), .mon(if2.slave));

  hls_deadlock_param_monitor #(.INST_MASK(5'b10100)) u3 (
    .clock(clk), .reset(rst[3]), .mon(if3.slave));

  hls_deadlock_param_monitor #(.CNT_W(4), .PERSIST(3)) u4 (
    .clock(clk), .reset(rst[4]), .mon(if4.slave));

  // Configuration of each instance as seen by the model.
  int p_persist[NI] = '{1, 4, 1, 1, 3};
  int p_cmax[NI]    = '{65535, 65535, 65535, 65535, 15};
  int p_gate[NI]    = '{0, 0, 1, 0, 0};
  int p_imask[NI]   = '{0, 0, 0, 5'b10100, 0};

  // Model: length of the current unbroken suspect run, and the reported view.
  int m_run[NI];
  bit m_blk[NI];
  int m_cnt[NI];
  int m_src[NI];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [2:0] a, input logic [8:0] idl,
                              input logic [4:0] ins, input logic [NI-1:0] r);
    for (int i = 0; i < NI; i++) begin
      logic [7:0] sv;
      bit         susp;
      bit         hold;
      bit         nb;
      int         low;
      sv   = {ins & 5'(p_imask[i]), a & 3'b110};
      susp = (sv != 8'd0) && !(p_gate[i] != 0 && idl == 9'h1FF);
      low  = 0;
      for (int b = 7; b >= 0; b--) if (sv[b]) low = b;
      hold = 1'b0;
`ifdef HLS_DEADLOCK_MON_STICKY_EN
      hold = m_blk[i];
`endif
      if (r[i]) begin
        m_run[i] = 0;
        m_blk[i] = 1'b0;
        m_cnt[i] = 0;
        m_src[i] = 0;
      end else if (!hold) begin
        m_run[i] = susp ? m_run[i] + 1 : 0;
        m_cnt[i] = (m_run[i] > p_cmax[i]) ? p_cmax[i] : m_run[i];
        nb       = (m_run[i] >= p_persist[i]);
        if (nb && !m_blk[i]) m_src[i] = low;
        m_blk[i] = nb;
      end
    end
  endtask

  task automatic check_all();
    logic        o_blk[NI];
    logic [31:0] o_cnt[NI];
    logic [31:0] o_src[NI];
    o_blk[0] = if0.block; o_cnt[0] = 32'(if0.stall_cnt); o_src[0] = 32'(if0.block_src);
    o_blk[1] = if1.block; o_cnt[1] = 32'(if1.stall_cnt); o_src[1] = 32'(if1.block_src);
    o_blk[2] = if2.block; o_cnt[2] = 32'(if2.stall_cnt); o_src[2] = 32'(if2.block_src);
    o_blk[3] = if3.block; o_cnt[3] = 32'(if3.stall_cnt); o_src[3] = 32'(if3.block_src);
    o_blk[4] = if4.block; o_cnt[4] = 32'(if4.stall_cnt); o_src[4] = 32'(if4.block_src);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.block", i),     32'(o_blk[i]), 32'(m_blk[i]));
      chk($sformatf("u%0d.stall_cnt", i), o_cnt[i],     32'(m_cnt[i]));
      chk($sformatf("u%0d.block_src", i), o_src[i],     32'(m_src[i]));
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [8:0] idl, input logic [4:0] ins);
    if0.axis_block_sigs = a; if0.inst_idle_sigs = idl; if0.inst_block_sigs = ins;
    if1.axis_block_sigs = a; if1.inst_idle_sigs = idl; if1.inst_block_sigs = ins;
    if2.axis_block_sigs = a; if2.inst_idle_sigs = idl; if2.inst_block_sigs = ins;
    if3.axis_block_sigs = a; if3.inst_idle_sigs = idl; if3.inst_block_sigs = ins;
    if4.axis_block_sigs = a; if4.inst_idle_sigs = idl; if4.inst_block_sigs = ins;
  endtask

  // One clock: drive on the falling edge, predict at the rising edge, compare 1ns later.
  task automatic apply(input logic [2:0] a, input logic [8:0] idl,
                       input logic [4:0] ins, input logic [NI-1:0] r);
    @(negedge clk);
    drive(a, idl, ins);
    rst = r;
    @(posedge clk);
    model_update(a, idl, ins, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [NI-1:0] rr;
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 0; m_blk[i] = 1'b0; m_cnt[i] = 0; m_src[i] = 0;
    end
    drive(3'b000, 9'h000, 5'b00000);

    // Reset state, with suspect inputs present to show reset dominates.
    apply(3'b110, 9'h000, 5'b11111, '1);
    apply(3'b000, 9'h000, 5'b00000, '1);

    // Single-cycle suspect on the current-process stream.
    apply(3'b010, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);

    // Persistence window broken once, then held.
    for (int c = 0; c < 3; c++) apply(3'b010, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);
    for (int c = 0; c < 5; c++) apply(3'b010, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);

    // Idle gating: all idle hides the suspect, one busy instance exposes it.
    for (int c = 0; c < 3; c++) apply(3'b100, 9'h1FF, 5'b00000, '0);
    for (int c = 0; c < 2; c++) apply(3'b100, 9'h1FE, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);

    // Instance-block sources only.
    for (int c = 0; c < 3; c++) apply(3'b000, 9'h000, 5'b10100, '0);
    apply(3'b000, 9'h000, 5'b00000, '0);

    // Long stall: 4-bit counter saturates, then one instance is reset mid-stall.
    for (int c = 0; c < 24; c++) begin
      rr = (c == 20) ? 5'b10000 : 5'b00000;
      apply(3'b010, 9'h000, 5'b00000, rr);
    end

    // Block, then suspect drops for a while, then full reset.
    for (int c = 0; c < 4; c++) apply(3'b110, 9'h000, 5'b10100, '0);
    for (int c = 0; c < 5; c++) apply(3'b000, 9'h000, 5'b00000, '0);
    apply(3'b000, 9'h000, 5'b00000, '1);
    apply(3'b000, 9'h000, 5'b00000, '0);

    // Random traffic with occasional per-instance resets.
    for (int c = 0; c < 400; c++) begin
      logic [2:0] a;
      logic [8:0] idl;
      logic [4:0] ins;
      a   = 3'($urandom_range(7));
      ins = 5'($urandom);
      idl = ($urandom_range(3) == 0) ? 9'h1FF : 9'($urandom);
      for (int i = 0; i < NI; i++) rr[i] = ($urandom_range(39) == 0);
      apply(a, idl, ins, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
